// File: rtl/nibble_accum_pkg.sv
// nibble_accum_pkg: shared FSM states, slice width and counter sizing for nibble_accum
package nibble_accum_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/nibble_accum.sv
// nibble_accum: assembles LSB-first nibble results from a 4-bit adder slice into a word,
// feeding each nibble's carry back to the slice and presenting the word with a valid/ready handshake
module nibble_accum
    import nibble_accum_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIB_W-1:0]         nib_s,
    input  logic                     nib_c,
    output logic                     adder_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*NIBBLES-1:0] out_sum,
    output logic                     out_cout
);
    localparam int CW = cnt_width(NIBBLES);
    state_t                     state, state_nx;
    logic [CW-1:0]              cnt, cnt_nx;
    logic                       carry, carry_nx;
    logic [NIB_W*NIBBLES-1:0]   sum_nx;
    logic                       cout_nx;
    logic                       xfer, last;
    assign in_ready  = state != DONE;
    assign out_valid = state == DONE;
    assign adder_cin = (state == ACCUM) ? carry : 1'b0;
    assign xfer      = in_valid && in_ready;
    assign last      = cnt == CW'(NIBBLES - 1);
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        carry_nx = carry;
        sum_nx   = out_sum;
        cout_nx  = out_cout;
        if (clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            carry_nx = 1'b0;
        end else if (xfer) begin
            for (int i = 0; i < NIBBLES; i++)
                if (cnt == CW'(i)) sum_nx[i*NIB_W +: NIB_W] = nib_s;
            carry_nx = nib_c;
            // counter wraps to 0 on the final nibble so it never exceeds NIBBLES-1
            cnt_nx   = last ? '0 : cnt + CW'(1);
            state_nx = last ? DONE : ACCUM;
            cout_nx  = last ? nib_c : out_cout;
        end else if (state == DONE && out_ready) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            carry_nx = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            carry    <= carry_nx;
            out_sum  <= sum_nx;
            out_cout <= cout_nx;
        end
    end
endmodule

// File: tb/tb_nibble_accum.sv
// tb_nibble_accum: scoreboard bench pairing nibble_accum with a 4-bit adder model
module tb_nibble_accum;
    logic        clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 1;
    logic        in_ready, adder_cin, out_valid, out_cout, nib_c;
    logic [3:0]  nib_s, an = 0, bn = 0;
    logic [15:0] out_sum;
    logic        in_valid1 = 0, out_ready1 = 0;
    logic        in_ready1, adder_cin1, out_valid1, out_cout1, nib_c1;
    logic [3:0]  nib_s1, out_sum1;
    int          checks = 0, errors = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;

    always #5 clk = ~clk;

    assign {nib_c, nib_s}   = {1'b0, an} + {1'b0, bn} + {4'b0, adder_cin};
    assign {nib_c1, nib_s1} = 5'd9 + 5'd8 + {4'b0, adder_cin1};

    nibble_accum #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .nib_s(nib_s), .nib_c(nib_c), .adder_cin(adder_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
    );

    nibble_accum #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .in_valid(in_valid1), .in_ready(in_ready1),
        .nib_s(nib_s1), .nib_c(nib_c1), .adder_cin(adder_cin1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // carry into nibble k is the carry out of adding the lower 4k bits
    function automatic logic cin_exp(input logic [15:0] a, input logic [15:0] b, input int k);
        logic [16:0] m, s;
        if (k == 0) return 1'b0;
        m = (17'd1 << (4 * k)) - 17'd1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m);
        return s[4*k];
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h with no word expected", out_sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("word_sum", {16'b0, out_sum}, {16'b0, mon_e[15:0]});
                chk("word_cout", {31'b0, out_cout}, {31'b0, mon_e[16]});
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input int n,
                        input int gap_at, input int gap_len);
        if (n == 4) exp_q.push_back({1'b0, a} + {1'b0, b});
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                repeat (gap_len) begin
                    @(negedge clk);
                    chk("gap_cin", {31'b0, adder_cin}, {31'b0, cin_exp(a, b, k)});
                end
            end
            wait_ready();
            an = a[4*k +: 4];
            bn = b[4*k +: 4];
            in_valid = 1;
            chk("adder_cin", {31'b0, adder_cin}, {31'b0, cin_exp(a, b, k)});
            @(posedge clk);
            @(negedge clk);
            in_valid = 0;
        end
        if (n == 4) chk("valid_latency", {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra, rb;
        logic [16:0] full;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sum", {16'b0, out_sum}, 32'd0);
        chk("rst_out_cout", {31'b0, out_cout}, 32'd0);
        chk("rst_adder_cin", {31'b0, adder_cin}, 32'd0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        send(16'h1234, 16'h4321, 4, -1, 0);
        @(negedge clk);
        chk("idle_valid", {31'b0, out_valid}, 32'd0);
        chk("idle_ready", {31'b0, in_ready}, 32'd1);

        send(16'hFFFF, 16'h0001, 4, -1, 0);
        send(16'hFFFF, 16'h0001, 4, 2, 3);
        @(negedge clk);

        out_ready = 0;
        send(16'hABCD, 16'h5678, 4, -1, 0);
        full = 17'h0ABCD + 17'h05678;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_sum", {16'b0, out_sum}, {16'b0, full[15:0]});
            chk("stall_cout", {31'b0, out_cout}, {31'b0, full[16]});
        end
        @(posedge clk);
        #1 out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("release_valid", {31'b0, out_valid}, 32'd0);
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);

        send(16'hFFFF, 16'h0001, 2, -1, 0);
        clr = 1;
        @(negedge clk);
        clr = 0;
        chk("clr_cin", {31'b0, adder_cin}, 32'd0);
        chk("clr_valid", {31'b0, out_valid}, 32'd0);
        send(16'h00FF, 16'h0001, 4, -1, 0);
        @(negedge clk);

        send(16'hFFFF, 16'h0001, 3, -1, 0);
        rst_n = 0;
        #1;
        chk("midrst_sum", {16'b0, out_sum}, 32'd0);
        chk("midrst_cin", {31'b0, adder_cin}, 32'd0);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        #1 rst_n = 1;
        @(negedge clk);
        send(16'h00FF, 16'h0001, 4, -1, 0);

        for (int r = 0; r < 20; r++) begin
            ra = 16'($urandom);
            rb = (r % 4 == 0) ? ~ra + 16'($urandom_range(0, 2)) : 16'($urandom);
            send(ra, rb, 4, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        chk("n1_in_ready", {31'b0, in_ready1}, 32'd1);
        chk("n1_cin", {31'b0, adder_cin1}, 32'd0);
        in_valid1 = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 0;
        chk("n1_valid", {31'b0, out_valid1}, 32'd1);
        chk("n1_sum", {28'b0, out_sum1}, 32'h1);
        chk("n1_cout", {31'b0, out_cout1}, 32'd1);
        chk("n1_busy", {31'b0, in_ready1}, 32'd0);
        out_ready1 = 1;
        @(negedge clk);
        chk("n1_idle", {31'b0, out_valid1}, 32'd0);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_accum.md
NIBBLE_ACCUM -- requirements
Module: nibble_accum

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices per operand word (legal range 1..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: clr  input  1  synchronous abort; discards any partial word.
REQ-005 Port: in_valid  input  1  upstream nibble result present.
REQ-006 Port: in_ready  output  1  block can accept a nibble this cycle.
REQ-007 Port: nib_s  input  4  sum bits s3..s0 from the 4-bit adder slice.
REQ-008 Port: nib_c  input  1  carry-out c3 from the 4-bit adder slice.
REQ-009 Port: adder_cin  output  1  carry-in fed back to the adder slice for the current nibble.
REQ-010 Port: out_valid  output  1  assembled word available.
REQ-011 Port: out_ready  input  1  downstream accepts word.
REQ-012 Port: out_sum  output  4*NIBBLES  assembled sum, nibble 0 in bits [3:0].
REQ-013 Port: out_cout  output  1  final carry-out of the most significant nibble.

Function
REQ-014 The block SHALL implement FSM states IDLE (no nibble held), ACCUM (1..NIBBLES-1 nibbles held), and DONE (word complete).
REQ-015 A nibble transfer SHALL occur exactly when in_valid && in_ready at a rising edge.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE; it SHALL NOT depend combinationally on in_valid.
REQ-017 adder_cin SHALL be 0 in IDLE and equal the registered carry (nib_c of the previous transfer) in ACCUM; 0 in DONE.
REQ-018 Transfer k (k = 0..NIBBLES-1, LSB first) SHALL write nib_s into out_sum[4k+3:4k] and register nib_c as the carry; the counter SHALL increment by 1.
REQ-019 Transitions: IDLE->ACCUM on transfer when NIBBLES>1; IDLE->DONE on transfer when NIBBLES=1; ACCUM->DONE on transfer k=NIBBLES-1; otherwise hold.
REQ-020 On entry to DONE, out_valid SHALL rise the cycle after the final transfer, and out_cout SHALL equal nib_c of that transfer.
REQ-021 In DONE, out_valid, out_sum and out_cout SHALL remain stable until out_valid && out_ready; then DONE->IDLE, clearing the counter and carry; out_sum need not clear.
REQ-022 out_valid SHALL be 0 in IDLE and ACCUM.
REQ-023 clr SHALL force IDLE, clear the counter, carry and out_valid at the next edge, with priority over any simultaneous input or output handshake.
REQ-024 in_valid low in ACCUM SHALL hold all state (gaps between nibbles allowed, carry preserved).
REQ-025 Counter width SHALL be max(1, clog2(NIBBLES)); counter SHALL never exceed NIBBLES-1.

Reset
REQ-026 While rst_n=0: state=IDLE, counter=0, carry=0, out_sum=0, out_cout=0, out_valid=0, adder_cin=0; in_ready SHALL be 1 after reset release.
REQ-027 Reset asserted mid-word or in DONE SHALL discard the word with no out_valid pulse.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, ACCUM, DONE) and the nibble width constant (4).
REQ-029 No sub-module is required; the block SHALL be one module with a registered FSM, counter, carry register and result register.

Verification (bench pairs DUT with a 4-bit adder model driven by adder_cin)
REQ-030 a=0x1234, b=0x4321, NIBBLES=4, continuous valid -> out_sum=0x5555, out_cout=0, out_valid 1 cycle after 4th transfer.
REQ-031 a=0xFFFF, b=0x0001 -> adder_cin=1 on nibbles 1..3, out_sum=0x0000, out_cout=1.
REQ-032 Same as 031 with in_valid low 3 cycles between nibbles 1 and 2 -> identical result, carry held.
REQ-033 out_ready held low 5 cycles in DONE -> in_ready=0, outputs stable, one word delivered on release, IDLE next cycle.
REQ-034 clr after 2 nibbles, then a=0x00FF, b=0x0001 -> out_sum=0x0100, out_cout=0, no stale nibbles; repeat with rst_n pulse mid-word -> same.
REQ-035 NIBBLES=1, a=0x9, b=0x8 -> DONE after one transfer, out_sum=0x1, out_cout=1.
